// File: rtl/flasher_pkg.sv
// Encodings shared between the flasher datapath and the next-state generator.
package flasher_pkg;

    typedef enum logic [2:0] {
        INIT_STATE       = 3'd0,
        ONLED0_15_STATE  = 3'd1,
        OFFLED15_5_STATE = 3'd2,
        ONLED5_10_STATE  = 3'd3,
        OFFLED10_0_STATE = 3'd4,
        ONLED0_5_STATE   = 3'd5,
        OFFLED5_0_STATE  = 3'd6
    } main_state_t;

    typedef enum logic [1:0] {
        COUNT_DIS     = 2'b00,
        COUNT_UP_EN   = 2'b01,
        COUNT_DOWN_EN = 2'b10
    } count_state_t;

    localparam logic [4:0] KICK_CNT_HI = 5'd5;
    localparam logic [4:0] KICK_CNT_LO = 5'd0;
    localparam logic [4:0] CNT_MAX     = 5'd31;

    // Code 3'd7 has no state of its own; it folds onto INIT_STATE.
    function automatic main_state_t decode_state(input logic [2:0] code);
        return (code == 3'd7) ? INIT_STATE : main_state_t'(code);
    endfunction

endpackage

// File: rtl/flick_synchronizer.sv
// Multi-stage reset-clearable synchroniser for the raw flick switch.
module flick_synchronizer #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/flasher_datapath.sv
// Flasher register/counter half: main state, saturating lamp counter,
// flick synchroniser, kickback detect and thermometer lamp decode.
module flasher_datapath
    import flasher_pkg::*;
#(
    parameter int unsigned LED_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flick,
    input  logic [2:0]       main_state_n,
    input  logic [4:0]       counter_load,
    input  logic             counter_load_en,
    input  logic [1:0]       count_state,
    output logic [2:0]       main_state,
    output logic [4:0]       counter,
    output logic             flick_sync,
    output logic             kickback_match,
    output logic [LED_W-1:0] led
);

    main_state_t state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;

    flick_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_flick_sync (
        .clk(clk),
        .rst(rst),
        .d  (flick),
        .q  (flick_sync)
    );

    always_comb begin
        state_d = decode_state(main_state_n);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (counter_load_en) begin
            cnt_d = counter_load;
        end else begin
            case (count_state)
                COUNT_UP_EN: begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 5'd1;
                end
                COUNT_DOWN_EN: begin
                    if (cnt_q != '0) cnt_d = cnt_q - 5'd1;
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign main_state = state_q;
    assign counter    = cnt_q;

    // Registered-only terms keep the generator loop free of combinational cycles.
    assign kickback_match = flick_sync &
        (((state_q == OFFLED15_5_STATE) && (cnt_q == KICK_CNT_HI)) ||
         ((state_q == OFFLED10_0_STATE) && (cnt_q == KICK_CNT_LO)));

    always_comb begin
        led = '0;
        for (int unsigned i = 0; i < LED_W; i++) begin
            led[i] = (32'(cnt_q) > i);
        end
    end

endmodule
